// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO of ALU results with zero flag, carry masking and a saturating drop counter
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_result,
  input  logic          in_cout,
  input  logic [1:0]    in_op,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_result,
  output logic          out_cout,
  output logic [1:0]    out_op,
  output logic          out_zero,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [11:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = count != FULL;
  assign out_valid = count != '0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign {out_op, out_cout, out_zero, out_result} = mem[rd_ptr];
  // MUL and AND produce no meaningful carry, so it is masked at store time
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_op, in_cout & ~in_op[1], in_result == 8'h00, in_result};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_cnt <= '0;
    end else begin
      if (flush) begin
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (in_valid && !in_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed scenario tasks with hand-computed expectations for alu_result_buffer
module tb_alu_result_buffer;
  logic clk, rst_n, in_valid, in_cout, flush, out_ready;
  logic [7:0] in_result;
  logic [1:0] in_op;
  logic in_ready, out_valid, out_cout, out_zero;
  logic [7:0] out_result, drop_cnt;
  logic [1:0] out_op;
  logic [2:0] count;
  int vectors = 0;
  int miscompares = 0;

  alu_result_buffer #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result), .in_cout(in_cout),
    .in_op(in_op), .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_op(out_op), .out_zero(out_zero),
    .count(count), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] r, input logic [1:0] op, input logic c);
    in_valid = 1'b1;
    in_result = r;
    in_op = op;
    in_cout = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = 8'h00; in_cout = 1'b0; in_op = 2'b00;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    offer(8'h0C, 2'b00, 1'b1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", out_valid); end
    vectors++; if (out_result !== 8'h0C) begin miscompares++; $display("FAIL single_result got %h exp 0c", out_result); end
    vectors++; if (out_cout !== 1'b1) begin miscompares++; $display("FAIL single_cout got %b exp 1", out_cout); end
    vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("FAIL single_zero got %b exp 0", out_zero); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", count); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
    tick();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = 8'hF0 + 8'(i);
      offer(exp, 2'(i % 2), 1'b0);
      tick();
    end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", count); end
    offer(8'hF4, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL fill_drop got %0d exp 1", drop_cnt); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count_after_drop got %0d exp 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'hF0 + 8'(i);
      vectors++; if (out_result !== exp) begin miscompares++; $display("FAIL drain_order[%0d] got %h exp %h", i, out_result, exp); end
      vectors++; if (out_op !== 2'(i % 2)) begin miscompares++; $display("FAIL drain_op[%0d] got %b exp %b", i, out_op, 2'(i % 2)); end
      tick();
      if (i == 0) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL pop_full_in_ready got %b exp 1", in_ready); end
      end
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flags();
    offer(8'h00, 2'b10, 1'b1);
    tick();
    vectors++; if (out_zero !== 1'b1) begin miscompares++; $display("FAIL mul_zero got %b exp 1", out_zero); end
    vectors++; if (out_cout !== 1'b0) begin miscompares++; $display("FAIL mul_cout got %b exp 0", out_cout); end
    vectors++; if (out_op !== 2'b10) begin miscompares++; $display("FAIL mul_op got %b exp 10", out_op); end
    offer(8'h05, 2'b11, 1'b1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++; if (out_result !== 8'h05) begin miscompares++; $display("FAIL and_result got %h exp 05", out_result); end
    vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("FAIL and_zero got %b exp 0", out_zero); end
    vectors++; if (out_cout !== 1'b0) begin miscompares++; $display("FAIL and_cout got %b exp 0", out_cout); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL and_count got %0d exp 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    offer(8'h10, 2'b00, 1'b0);
    tick();
    offer(8'h11, 2'b01, 1'b1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(8'h12 + 8'(i), 2'b00, 1'b1);
      exp = 8'h10 + 8'(i);
      vectors++; if (out_result !== exp) begin miscompares++; $display("FAIL stream_head[%0d] got %h exp %h", i, out_result, exp); end
      tick();
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL stream_count[%0d] got %0d exp 2", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp = 8'h24 + 8'(i);
      vectors++; if (out_result !== exp) begin miscompares++; $display("FAIL stream_tail[%0d] got %h exp %h", i, out_result, exp); end
      tick();
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end_valid got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      offer(8'h30 + 8'(i), 2'b00, 1'b0);
      tick();
    end
    offer(8'h33, 2'b00, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d exp 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL flush_drop got %0d exp 1", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      offer(8'h40 + 8'(i), 2'b00, 1'b0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++; if (drop_cnt !== 8'd2) begin miscompares++; $display("FAIL flush_full_drop got %0d exp 2", drop_cnt); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_full_count got %0d exp 0", count); end
    offer(8'h55, 2'b01, 1'b1);
    tick();
    in_valid = 1'b0;
    vectors++; if (out_result !== 8'h55) begin miscompares++; $display("FAIL post_flush_head got %h exp 55", out_result); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    offer(8'h61, 2'b00, 1'b0);
    tick();
    offer(8'h62, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL pre_reset_count got %0d exp 2", count); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid got %b exp 0", out_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL async_count got %0d exp 0", count); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL async_drop got %0d exp 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    offer(8'h77, 2'b11, 1'b1);
    tick();
    in_valid = 1'b0;
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL first_push_count got %0d exp 1", count); end
    vectors++; if (out_result !== 8'h77) begin miscompares++; $display("FAIL first_push_result got %h exp 77", out_result); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_flags();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries held; SHALL be a power of two, 2..16.
REQ-002 Parameter CW, default 3, occupancy count width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  ALU result present this cycle.
REQ-006 in_result  input  8  ALU Result bus.
REQ-007 in_cout  input  1  ALU carry out.
REQ-008 in_op  input  2  ALU operation selector TT that produced the result: 00 ADD, 01 SUB, 10 MUL, 11 AND.
REQ-009 in_ready  output  1  buffer can accept an entry this cycle.
REQ-010 flush  input  1  synchronous clear of all stored entries.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  consumer accepts the head entry.
REQ-013 out_result  output  8  head entry result.
REQ-014 out_cout  output  1  head entry carry.
REQ-015 out_op  output  2  head entry operation code.
REQ-016 out_zero  output  1  head entry zero flag.
REQ-017 count  output  CW  number of stored entries.
REQ-018 drop_cnt  output  8  saturating count of rejected offers.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be (count != DEPTH), registered-state only; in_ready SHALL NOT depend on out_ready in the same cycle.
REQ-021 out_valid SHALL be (count != 0); out_* fields SHALL be driven from the head storage entry, with no combinational path from in_* to out_*.
REQ-022 Each entry SHALL store {in_op, in_cout, zero, in_result}, with zero = (in_result == 8'h00) computed at push.
REQ-023 For in_op 10 (MUL) and 11 (AND), the stored cout SHALL be forced to 0 regardless of in_cout.
REQ-024 For in_op 00/01, a stored in_result[7:4] that is nonzero SHALL still be stored unmodified; the buffer SHALL NOT alter result bits.
REQ-025 Latency: an entry pushed at edge N SHALL appear on out_* with out_valid=1 from edge N onward, i.e. it is visible one cycle after being offered; there is no bypass when empty.
REQ-026 Ordering SHALL be strict FIFO; the write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 Simultaneous push and pop with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-028 Push when full is impossible by REQ-020; a pop while full SHALL make in_ready=1 on the following cycle.
REQ-029 Pop when empty is impossible by REQ-021; out_ready while empty SHALL have no effect.
REQ-030 Drop: when in_valid && !in_ready, drop_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-031 When flush=1 at an edge, count and both pointers SHALL become 0, and any same-cycle push or pop SHALL be discarded; drop_cnt SHALL NOT be cleared.
REQ-032 An offer rejected in a flush cycle because the buffer was full SHALL still increment drop_cnt.
REQ-033 Storage contents SHALL NOT require reset; out_* data fields are don't-care while out_valid=0.

Reset
REQ-034 On rst_n=0, asynchronously: count=0, read and write pointers=0, drop_cnt=0, out_valid=0, in_ready=1.
REQ-035 Deassertion of rst_n SHALL be synchronised externally; the first push SHALL be accepted on the first rising edge with rst_n=1.
REQ-036 Reset asserted mid-operation SHALL discard all entries immediately; no partial pop SHALL be observable.

Verification
REQ-037 Single push: in_result=8'h0C, in_op=00, in_cout=1 with out_ready=0 -> next cycle out_valid=1, out_result=0C, out_cout=1, out_zero=0, count=1.
REQ-038 Fill: push 5 entries (DEPTH=4) with out_ready=0 -> in_ready=0 after the 4th push, drop_cnt=1, count=4; then drain and check FIFO order.
REQ-039 Flag rules: push MUL result 8'h00 with in_cout=1 -> out_zero=1, out_cout=0; push AND result 8'h05 -> out_zero=0, out_cout=0.
REQ-040 Steady stream: continuous push and pop at count=2 for 20 cycles -> count stays 2, with the pointers wrapping correctly.
REQ-041 Flush with a simultaneous push while count=3 -> next cycle count=0, out_valid=0, drop_cnt unchanged.
REQ-042 Assert rst_n=0 mid-cycle while count=2 -> out_valid=0 and count=0 without waiting for a clock edge.
